// File: rtl/fas_peak_analyzer.sv
// Peak-bin search over one 16-point complex FFT frame: serial |X[k]|^2 with a
// three-stage pipeline, plus one pending frame so frames can arrive back-to-back.
module fas_peak_analyzer #(
  parameter int unsigned SKIP_DC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        done,
  output logic [3:0]  freq,
  output logic [31:0] max_mag,
  output logic        busy,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        pending_v;
  logic [31:0] frame [16];
  logic [31:0] work  [16];
  logic [31:0] pend  [16];

  logic               s1_v;
  logic [3:0]         s1_idx;
  logic [30:0]        sq_re;
  logic [30:0]        sq_im;
  logic               s2_v;
  logic [3:0]         s2_idx;
  logic [31:0]        s2_mag;
  logic               run_any;
  logic [31:0]        run_max;
  logic [3:0]         run_idx;

  logic signed [15:0] cur_re;
  logic signed [15:0] cur_im;
  logic signed [31:0] p_re;
  logic signed [31:0] p_im;
  logic               cand;
  logic               upd;
  logic [31:0]        nxt_max;
  logic [3:0]         nxt_idx;

  always_comb begin
    frame[0]  = fft_d0;
    frame[1]  = fft_d1;
    frame[2]  = fft_d2;
    frame[3]  = fft_d3;
    frame[4]  = fft_d4;
    frame[5]  = fft_d5;
    frame[6]  = fft_d6;
    frame[7]  = fft_d7;
    frame[8]  = fft_d8;
    frame[9]  = fft_d9;
    frame[10] = fft_d10;
    frame[11] = fft_d11;
    frame[12] = fft_d12;
    frame[13] = fft_d13;
    frame[14] = fft_d14;
    frame[15] = fft_d15;
  end

  always_comb begin
    cur_re = work[cnt][31:16];
    cur_im = work[cnt][15:0];
    p_re   = cur_re * cur_re;
    p_im   = cur_im * cur_im;
  end

  // Compare stage is combinational so the final bin's result can be published
  // at the same edge that it is judged.
  always_comb begin
    cand    = s2_v && !((SKIP_DC != 0) && (s2_idx == 4'd0));
    upd     = cand && (!run_any || (s2_mag > run_max));
    nxt_max = upd ? s2_mag : run_max;
    nxt_idx = upd ? s2_idx : run_idx;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pending_v <= 1'b0;
      done      <= 1'b0;
      freq      <= '0;
      max_mag   <= '0;
      overflow  <= 1'b0;
      s1_v      <= 1'b0;
      s1_idx    <= '0;
      sq_re     <= '0;
      sq_im     <= '0;
      s2_v      <= 1'b0;
      s2_idx    <= '0;
      s2_mag    <= '0;
      run_any   <= 1'b0;
      run_max   <= '0;
      run_idx   <= '0;
    end else begin
      done <= 1'b0;

      s1_v   <= (state == SCAN);
      s1_idx <= cnt;
      sq_re  <= p_re[30:0];
      sq_im  <= p_im[30:0];
      s2_v   <= s1_v;
      s2_idx <= s1_idx;
      s2_mag <= {1'b0, sq_re} + {1'b0, sq_im};

      if (upd) begin
        run_any <= 1'b1;
        run_max <= nxt_max;
        run_idx <= nxt_idx;
      end

      case (state)
        IDLE: begin
          if (fft_valid) begin
            work    <= frame;
            state   <= SCAN;
            cnt     <= '0;
            run_any <= 1'b0;
            run_max <= '0;
            run_idx <= '0;
          end
        end
        SCAN, DRAIN: begin
          cnt <= cnt + 4'd1;
          if (state == SCAN && cnt == 4'd15) begin
            state <= DRAIN;
            cnt   <= '0;
          end else if (state == DRAIN && cnt == 4'd1) begin
            state   <= DONE;
            cnt     <= '0;
            done    <= 1'b1;
            freq    <= nxt_idx;
            max_mag <= nxt_max;
          end
          if (fft_valid) begin
            if (!pending_v) begin
              pend      <= frame;
              pending_v <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        DONE: begin
          cnt     <= '0;
          run_any <= 1'b0;
          run_max <= '0;
          run_idx <= '0;
          if (pending_v) begin
            work  <= pend;
            state <= SCAN;
            if (fft_valid)
              pend <= frame;
            else
              pending_v <= 1'b0;
          end else if (fft_valid) begin
            // Nothing pending: start the new frame immediately rather than
            // parking it, which keeps the same 19-cycle frame spacing.
            work  <= frame;
            state <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fas_peak_analyzer.sv
// Scoreboard bench: stimulus pushes expected (freq, max_mag, done cycle) per
// instance; negedge monitors pop and compare on every done pulse.
module tb_fas_peak_analyzer;

  typedef struct {
    logic [3:0]  f;
    logic [31:0] m;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fft_valid;
  logic [31:0] d [16];
  logic        done0, busy0, ovf0, done1, busy1, ovf1;
  logic [3:0]  freq0, freq1;
  logic [31:0] mag0, mag1;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fas_peak_analyzer #(.SKIP_DC(0)) dut0 (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
    .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
    .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .done(done0), .freq(freq0), .max_mag(mag0), .busy(busy0), .overflow(ovf0)
  );

  fas_peak_analyzer #(.SKIP_DC(1)) dut1 (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
    .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
    .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .done(done1), .freq(freq1), .max_mag(mag1), .busy(busy1), .overflow(ovf1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) begin
        chk("unexpected_done0", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("freq0", {28'd0, freq0}, {28'd0, e.f});
        chk("max_mag0", mag0, e.m);
        chk("done_cycle0", cyc, e.c);
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        chk("unexpected_done1", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("freq1", {28'd0, freq1}, {28'd0, e.f});
        chk("max_mag1", mag1, e.m);
        chk("done_cycle1", cyc, e.c);
      end
    end
  end

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < 16; i++) d[i] = v;
  endtask

  task automatic expect2(input logic [3:0] f0, input logic [31:0] m0,
                         input logic [3:0] f1, input logic [31:0] m1, input int c);
    exp_t e;
    e.f = f0; e.m = m0; e.c = c; q0.push_back(e);
    e.f = f1; e.m = m1; e.c = c; q1.push_back(e);
  endtask

  // Drive fft_valid so that it is sampled at the edge where cyc becomes t
  // (or the next edge if t has passed); e returns that edge's cycle number.
  task automatic send_at(input int t, output int e);
    @(negedge clk);
    while (cyc + 1 < t) @(negedge clk);
    fft_valid = 1'b1;
    @(posedge clk);
    #1;
    fft_valid = 1'b0;
    e = cyc;
  endtask

  task automatic rst_at(input int t);
    @(negedge clk);
    while (cyc + 1 < t) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !busy0 && !busy1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, nb;
    rst = 1'b1;
    fft_valid = 1'b0;
    fill('0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_freq", {28'd0, freq0}, 32'd0);
    chk("rst_mag", mag0, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_ovf", {31'd0, ovf0}, 32'd0);

    // Bins 1 and 15 equal at 4.0 real: lowest index wins.
    fill('0);
    d[1] = 32'h0400_0000;
    d[15] = 32'h0400_0000;
    send_at(0, e0);
    expect2(4'd1, 32'h0010_0000, 4'd1, 32'h0010_0000, e0 + 18);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy0) nb++;
      else break;
    end
    chk("busy_cycles", nb, 32'd19);
    wait_idle();

    // Most negative real and imag on bin 7.
    fill(32'h0100_FF00);
    d[7] = 32'h8000_8000;
    send_at(0, e0);
    expect2(4'd7, 32'h8000_0000, 4'd7, 32'h8000_0000, e0 + 18);
    wait_idle();

    // All-zero frame: DC-skip instance reports bin 1.
    fill('0);
    send_at(0, e0);
    expect2(4'd0, 32'd0, 4'd1, 32'd0, e0 + 18);
    wait_idle();

    // Tie between bins 2 and 9 with mixed signs.
    fill('0);
    d[2] = 32'h0300_FD00;
    d[9] = 32'h0300_FD00;
    send_at(0, e0);
    expect2(4'd2, 32'h0012_0000, 4'd2, 32'h0012_0000, e0 + 18);
    wait_idle();

    // Back-to-back A, B (pending), then C dropped.
    fill('0);
    d[3] = 32'h0100_0000;
    send_at(0, e0);
    expect2(4'd3, 32'h0001_0000, 4'd3, 32'h0001_0000, e0 + 18);
    fill('0);
    d[12] = 32'h0200_0000;
    send_at(e0 + 5, e1);
    expect2(4'd12, 32'h0004_0000, 4'd12, 32'h0004_0000, e0 + 37);
    @(negedge clk);
    chk("ovf_after_b", {31'd0, ovf0}, 32'd0);
    fill(32'h7FFF_7FFF);
    send_at(e0 + 6, e1);
    @(negedge clk);
    chk("ovf_after_c", {31'd0, ovf0}, 32'd1);
    wait_idle();
    chk("ovf_sticky", {31'd0, ovf1}, 32'd1);

    // Reset mid-scan aborts the frame and clears the sticky overflow.
    fill('0);
    d[2] = 32'h0100_0000;
    send_at(0, e0);
    rst_at(e0 + 10);
    @(negedge clk);
    chk("midrst_freq", {28'd0, freq0}, 32'd0);
    chk("midrst_mag", mag0, 32'd0);
    chk("midrst_busy", {31'd0, busy0}, 32'd0);
    chk("midrst_ovf", {31'd0, ovf0}, 32'd0);
    fill('0);
    d[5] = 32'h0000_0500;
    send_at(e0 + 15, e1);
    expect2(4'd5, 32'h0019_0000, 4'd5, 32'h0019_0000, e0 + 33);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
